grid_pattern_selector: RTL and testbench

GRID_PATTERN_SELECTOR -- requirements
Module: grid_pattern_selector

---
 rtl/grid_pkg.sv | 15 +
 rtl/grid_pattern_selector_dwell_counter.sv | 34 +++
 rtl/grid_pattern_selector.sv | 111 +++++++++++
 tb/tb_grid_pattern_selector.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared constants and types for the grid pattern selector.
// Default grid geometry, packed grid type and request state encoding.
package grid_pkg;

    localparam int unsigned GRID_ROWS = 16;
    localparam int unsigned GRID_COLS = 16;

    typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0] grid_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/grid_pattern_selector_dwell_counter.sv
// Counts frame ticks while auto-cycling is enabled.
// Raises expire on the tick that reaches max(limit,1).
module dwell_counter
    import grid_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               clear,
    input  logic               enable,
    input  logic [DWELL_W-1:0] limit,
    output logic               expire
);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W:0]   w_next;

    assign w_next = {1'b0, r_cnt} + {{DWELL_W{1'b0}}, 1'b1};
    // limit of 0 behaves as 1: w_next is always >= 1
    assign expire = enable && tick && !clear && (w_next >= {1'b0, limit});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!enable || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= expire ? '0 : w_next[DWELL_W-1:0];
        end
    end

endmodule

// File: rtl/grid_pattern_selector.sv
// Frame-synchronous selector of one of NCH grid patterns, with manual
// requests applied at the next frame tick and optional auto-cycling.
module grid_pattern_selector
    import grid_pkg::*;
#(
    parameter int ROWS    = GRID_ROWS,
    parameter int COLS    = GRID_COLS,
    parameter int NCH     = 8,
    parameter int DWELL_W = 8,
    localparam int SEL_W  = $clog2(NCH),
    localparam int GW     = ROWS * COLS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH*GW-1:0]   data,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_valid,
    input  logic                frame_tick,
    input  logic                auto_en,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [GW-1:0]       grid_out,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                switched,
    output logic                busy
);

    localparam logic [SEL_W:0]   NCH_W  = (SEL_W+1)'(NCH);
    localparam logic [SEL_W-1:0] LAST_W = SEL_W'(NCH - 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_pending_sel;
    logic [SEL_W-1:0]   r_cur_sel;
    logic [GW-1:0]      r_grid;
    logic               r_switched;

    logic               w_legal;
    logic               w_apply;
    logic               w_expire;
    logic [SEL_W-1:0]   w_auto_sel;
    logic [SEL_W-1:0]   w_next_sel;
    logic [GW-1:0]      w_chan [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign w_chan[k] = data[k*GW +: GW];
    end

    assign w_legal    = sel_valid && ({1'b0, sel} < NCH_W);
    assign w_apply    = (r_state == PENDING) && frame_tick;
    assign w_auto_sel = (r_cur_sel == LAST_W) ? '0 : r_cur_sel + 1'b1;

    // A pending manual request outranks an auto advance on the same tick
    always_comb begin
        w_next_sel = r_cur_sel;
        if (w_apply) begin
            w_next_sel = r_pending_sel;
        end else if (w_expire) begin
            w_next_sel = w_auto_sel;
        end
    end

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (reset),
        .tick   (frame_tick),
        .clear  (w_apply),
        .enable (auto_en),
        .limit  (dwell),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pending_sel <= '0;
            r_cur_sel     <= '0;
            r_grid        <= '0;
            r_switched    <= 1'b0;
        end else begin
            r_switched <= (w_next_sel != r_cur_sel);
            r_cur_sel  <= w_next_sel;
            if (frame_tick) begin
                r_grid <= w_chan[w_next_sel];
            end
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_pending_sel <= sel;
                        r_state       <= PENDING;
                    end
                end
                PENDING: begin
                    // A request arriving with the applying tick stays pending
                    if (w_legal) begin
                        r_pending_sel <= sel;
                    end else if (frame_tick) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grid_out = r_grid;
    assign cur_sel  = r_cur_sel;
    assign switched = r_switched;
    assign busy     = (r_state == PENDING);

endmodule

// File: tb/tb_grid_pattern_selector.sv
// Scoreboard bench for grid_pattern_selector: driver pushes model predictions,
// monitor pops and compares after every rising edge.
module tb_grid_pattern_selector;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int NCH  = 8;
    localparam int NCH2 = 6;
    localparam int DW   = 8;
    localparam int GW   = ROWS * COLS;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH*GW-1:0] data = '0;
    logic [2:0]        sel = '0;
    logic              sel_valid = 1'b0;
    logic              frame_tick = 1'b0;
    logic              auto_en = 1'b0;
    logic [DW-1:0]     dwell = '0;
    logic [GW-1:0]     grid_out;
    logic [2:0]        cur_sel;
    logic              switched;
    logic              busy;

    logic [NCH2*GW-1:0] data2 = '0;
    logic [2:0]         sel2 = '0;
    logic               sel_valid2 = 1'b0;
    logic               auto_en2 = 1'b0;
    logic [DW-1:0]      dwell2 = '0;
    logic [GW-1:0]      grid_out2;
    logic [2:0]         cur_sel2;
    logic               switched2;
    logic               busy2;

    grid_pattern_selector #(.ROWS(ROWS), .COLS(COLS), .NCH(NCH), .DWELL_W(DW)) dut (
        .clk(clk), .reset(reset), .data(data), .sel(sel), .sel_valid(sel_valid),
        .frame_tick(frame_tick), .auto_en(auto_en), .dwell(dwell),
        .grid_out(grid_out), .cur_sel(cur_sel), .switched(switched), .busy(busy)
    );

    grid_pattern_selector #(.ROWS(ROWS), .COLS(COLS), .NCH(NCH2), .DWELL_W(DW)) dut6 (
        .clk(clk), .reset(reset), .data(data2), .sel(sel2), .sel_valid(sel_valid2),
        .frame_tick(frame_tick), .auto_en(auto_en2), .dwell(dwell2),
        .grid_out(grid_out2), .cur_sel(cur_sel2), .switched(switched2), .busy(busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [GW-1:0] grid;
        int            cur;
        bit            busy;
        bit            sw;
    } exp_t;

    exp_t          q[$];
    logic [GW-1:0] dat [NCH];
    int            n_checks = 0;
    int            n_fail = 0;

    // reference state: what the selector should be showing, in plain terms
    int            m_cur = 0, m_pend = 0, m_cnt = 0;
    bit            m_pv = 0, m_sw = 0;
    logic [GW-1:0] m_grid = '0;

    bit            nx_sv2 = 0;
    int            nx_s2 = 0;

    task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_data();
        for (int k = 0; k < NCH; k++) data[k*GW +: GW] = dat[k];
        for (int k = 0; k < NCH2; k++) data2[k*GW +: GW] = dat[k];
    endtask

    task automatic model(input bit rn, input bit sv, input int s, input bit ft,
                         input bit ae, input int dw);
        int nxt;
        if (!rn) begin
            m_cur = 0; m_pend = 0; m_pv = 0; m_cnt = 0; m_sw = 0; m_grid = '0;
            return;
        end
        nxt = m_cur;
        if (ft && m_pv) begin
            nxt = m_pend;
            m_cnt = 0;
        end else if (ft && ae) begin
            m_cnt++;
            if (m_cnt >= ((dw < 1) ? 1 : dw)) begin
                nxt = (m_cur + 1) % NCH;
                m_cnt = 0;
            end
        end
        if (!ae) m_cnt = 0;
        if (ft) begin
            m_grid = dat[nxt];
            m_pv = 0;
        end
        if (sv && s < NCH) begin
            m_pv = 1;
            m_pend = s;
        end
        m_sw = (nxt != m_cur);
        m_cur = nxt;
    endtask

    task automatic step(input bit rn, input bit sv, input int s, input bit ft,
                        input bit ae, input int dw);
        exp_t e;
        @(negedge clk);
        reset = rn; sel_valid = sv; sel = 3'(s); frame_tick = ft;
        auto_en = ae; dwell = DW'(dw);
        sel_valid2 = nx_sv2; sel2 = 3'(nx_s2);
        if (!rn) begin
            #1;
            chk("async_grid", grid_out, '0);
            chk("async_cur", GW'(cur_sel), '0);
            chk("async_busy", GW'(busy), '0);
            chk("async_sw", GW'(switched), '0);
        end
        model(rn, sv, s, ft, ae, dw);
        e.grid = m_grid; e.cur = m_cur; e.busy = m_pv; e.sw = m_sw;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit ae, input int dw);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, ae, dw);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grid_out", grid_out, e.grid);
                chk("cur_sel", GW'(cur_sel), GW'(e.cur));
                chk("busy", GW'(busy), GW'(e.busy));
                chk("switched", GW'(switched), GW'(e.sw));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int seq[6];
        int exp_seq[6];
        bit rn, sv, ft, ae;
        int s, dw;
        exp_seq = '{6, 7, 7, 0, 0, 1};

        for (int k = 0; k < NCH; k++) dat[k] = {ROWS{16'hAAAA + 16'(k)}};
        load_data();

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        chk("first_tick_grid", grid_out, {ROWS{16'hAAAA}});

        // manual request with a 4-cycle wait before the tick
        step(1, 1, 3, 0, 0, 0);
        idle(4, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        chk("req3_cur", GW'(cur_sel), GW'(3));
        chk("req3_sw", GW'(switched), GW'(1));
        chk("req3_grid", grid_out, {ROWS{16'hAAAD}});

        // last request wins
        step(1, 1, 2, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        chk("last_wins_cur", GW'(cur_sel), GW'(5));

        // auto cycling from channel 6, dwell 2
        step(1, 1, 6, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle(1, 1, 2);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 1, 1, 2);
            @(posedge clk); #2;
            seq[i] = int'(cur_sel);
            idle(1, 1, 2);
        end
        for (int i = 0; i < 6; i++) chk($sformatf("auto_seq%0d", i), GW'(seq[i]), GW'(exp_seq[i]));
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 1, 0);
            idle(1, 1, 0);
        end

        // request coincident with a tick in IDLE, then manual vs auto expiry
        idle(1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        idle(1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle(1, 1, 1);
        step(1, 1, 4, 0, 1, 1);
        step(1, 0, 0, 1, 1, 1);
        @(posedge clk); #2;
        chk("manual_over_auto", GW'(cur_sel), GW'(4));

        // reset while a request is pending
        step(1, 1, 4, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        idle(1, 0, 0);

        // out-of-range selects on the 6-channel instance
        nx_sv2 = 1; nx_s2 = 6;
        step(1, 0, 0, 0, 0, 0);
        nx_s2 = 7;
        step(1, 0, 0, 0, 0, 0);
        nx_sv2 = 0;
        step(1, 0, 0, 0, 0, 0);
        #2;
        chk("illegal_busy", GW'(busy2), '0);
        chk("illegal_cur", GW'(cur_sel2), '0);
        nx_sv2 = 1; nx_s2 = 5;
        step(1, 0, 0, 0, 0, 0);
        nx_sv2 = 0;
        step(1, 0, 0, 0, 0, 0);
        #2;
        chk("legal6_busy", GW'(busy2), GW'(1));
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        #2;
        chk("legal6_cur", GW'(cur_sel2), GW'(5));

        // randomized traffic with fresh pattern data
        for (int k = 0; k < NCH; k++) dat[k] = {8{$urandom()}};
        load_data();
        ae = 0; dw = 2;
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 399) != 0);
            sv = ($urandom_range(0, 4) == 0);
            s  = int'($urandom_range(0, 7));
            ft = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) ae = !ae;
            if ($urandom_range(0, 39) == 0) dw = int'($urandom_range(0, 3));
            step(rn, sv, s, ft, ae, dw);
        end
        idle(3, 0, 0);
        @(posedge clk); #2;
        chk("queue_drained", GW'(q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
